// File: rtl/battleship_pkg.sv
// Shared types and helpers for the fleet placer.
// FLEET_PLACER_UNDO_EN adds the StClear state used by undo.
package battleship_pkg;

   localparam int unsigned DefRows     = 6;
   localparam int unsigned DefCols     = 6;
   localparam int unsigned DefNumShips = 3;
   localparam logic [11:0] DefShipLens = 12'h432;

   localparam logic [1:0] ErrNone        = 2'b00;
   localparam logic [1:0] ErrBadCell     = 2'b01;
   localparam logic [1:0] ErrOutOfBounds = 2'b10;
   localparam logic [1:0] ErrOverlap     = 2'b11;

`ifdef FLEET_PLACER_UNDO_EN
   typedef enum logic [2:0] {StIdle, StWait, StCheck, StCommit, StDone, StClear} state_e;
`else
   typedef enum logic [2:0] {StIdle, StWait, StCheck, StCommit, StDone} state_e;
`endif

   // Length of ship idx from a packed nibble table; 0 past the end of the table.
   function automatic int unsigned ship_len(input logic [63:0] lens, input int unsigned idx);
      if (idx > 15) return 0;
      return 32'(lens[4*idx +: 4]);
   endfunction

   function automatic int unsigned cell_idx(input int unsigned r, input int unsigned c,
                                            input int unsigned cols);
      return r * cols + c;
   endfunction

endpackage

// File: rtl/ship_cell_walker.sv
// Walks the cells of one ship: loads anchor index, direction and length, then steps one
// cell per cycle. Shared by the overlap check, commit and clear passes.
module ship_cell_walker #(
   parameter int unsigned COLS = 6,
   parameter int unsigned XW   = 6,
   parameter int unsigned IW   = 7
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load_i,
   input  logic [IW-1:0] base_i,
   input  logic          vert_i,
   input  logic [3:0]    len_i,
   input  logic          rewind_i,
   input  logic          step_i,
   output logic [XW-1:0] cell_o,
   output logic          last_o
);

   logic [IW-1:0] base_q, base_d, stride_q, stride_d, cur_q, cur_d;
   logic [3:0]    k_q, k_d, len_q, len_d;

   // Next-state: load a new ship, rewind to its anchor, or advance one cell.
   always_comb begin
      base_d   = base_q;
      stride_d = stride_q;
      cur_d    = cur_q;
      k_d      = k_q;
      len_d    = len_q;
      if (load_i) begin
         base_d   = base_i;
         stride_d = vert_i ? IW'(COLS) : IW'(1);
         cur_d    = base_i;
         k_d      = 4'd0;
         len_d    = len_i;
      end else if (rewind_i) begin
         cur_d = base_q;
         k_d   = 4'd0;
      end else if (step_i) begin
         cur_d = cur_q + stride_q;
         k_d   = k_q + 4'd1;
      end
   end

   // Walker state registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         base_q   <= '0;
         stride_q <= '0;
         cur_q    <= '0;
         k_q      <= '0;
         len_q    <= '0;
      end else begin
         base_q   <= base_d;
         stride_q <= stride_d;
         cur_q    <= cur_d;
         k_q      <= k_d;
         len_q    <= len_d;
      end
   end

   assign cell_o = cur_q[XW-1:0];
   assign last_o = (k_q == len_q - 4'd1);

endmodule

// File: rtl/fleet_placer.sv
// Places a fleet of ships on a grid one command at a time, with bounds and overlap checks.
// Optional undo of the last placed ship: define FLEET_PLACER_UNDO_EN.
module fleet_placer
   import battleship_pkg::*;
#(
   parameter int unsigned             ROWS      = DefRows,
   parameter int unsigned             COLS      = DefCols,
   parameter int unsigned             NUM_SHIPS = DefNumShips,
   parameter logic [4*NUM_SHIPS-1:0]  SHIP_LENS = DefShipLens
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             start,
   input  logic                             place,
   input  logic [$clog2(ROWS)-1:0]          row,
   input  logic [$clog2(COLS)-1:0]          col,
   input  logic                             vert,
   input  logic                             undo,
   output logic [ROWS*COLS-1:0]             ships,
   output logic [$clog2(NUM_SHIPS+1)-1:0]   cur_ship,
   output logic                             busy,
   output logic                             placed,
   output logic                             err_valid,
   output logic [1:0]                       err_code,
   output logic                             done
);

   localparam int unsigned NumCells = ROWS * COLS;
   localparam int unsigned SW       = $clog2(NUM_SHIPS + 1);
   localparam int unsigned XW       = $clog2(NumCells);
   localparam int unsigned IW       = XW + 1;

   state_e              state_q, state_d;
   logic [NumCells-1:0] ships_q, ships_d;
   logic [SW-1:0]       cur_q, cur_d;
   logic                placed_q, placed_d, err_valid_q, err_valid_d;
   logic [1:0]          err_code_q, err_code_d;

   logic          w_load, w_vert, w_rewind, w_step, w_last;
   logic [IW-1:0] w_base, place_base;
   logic [3:0]    w_len;
   logic [XW-1:0] w_cell;

   int unsigned cmd_len;
   logic        bad_cell, oob;

   assign cmd_len    = ship_len(64'(SHIP_LENS), 32'(cur_q));
   assign place_base = IW'(cell_idx(32'(row), 32'(col), COLS));
   assign bad_cell   = (32'(row) >= ROWS) || (32'(col) >= COLS);
   assign oob        = vert ? (32'(row) + cmd_len > ROWS) : (32'(col) + cmd_len > COLS);

`ifdef FLEET_PLACER_UNDO_EN
   logic [IW-1:0] hist_base_q [NUM_SHIPS];
   logic          hist_vert_q [NUM_SHIPS];
   logic          hist_we;
   logic [SW-1:0] prev_idx;
   int unsigned   prev_len;

   assign prev_idx = cur_q - SW'(1);
   assign prev_len = ship_len(64'(SHIP_LENS), 32'(prev_idx));

   // Record each accepted command; a slot is only trusted once its ship commits.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < NUM_SHIPS; i++) begin
            hist_base_q[i] <= '0;
            hist_vert_q[i] <= 1'b0;
         end
      end else if (hist_we) begin
         hist_base_q[cur_q] <= place_base;
         hist_vert_q[cur_q] <= vert;
      end
   end
`else
   logic unused_undo;
   assign unused_undo = undo;
`endif

   // Placement FSM next-state and datapath control.
   always_comb begin
      state_d     = state_q;
      ships_d     = ships_q;
      cur_d       = cur_q;
      placed_d    = 1'b0;
      err_valid_d = 1'b0;
      err_code_d  = err_code_q;
      w_load      = 1'b0;
      w_rewind    = 1'b0;
      w_step      = 1'b0;
      w_base      = place_base;
      w_vert      = vert;
      w_len       = 4'(cmd_len);
`ifdef FLEET_PLACER_UNDO_EN
      hist_we     = 1'b0;
`endif
      unique case (state_q)
         StIdle: begin
            if (start) begin
               ships_d = '0;
               cur_d   = '0;
               state_d = StWait;
            end
         end
         StWait: begin
`ifdef FLEET_PLACER_UNDO_EN
            if (undo && cur_q != '0) begin
               w_load  = 1'b1;
               w_base  = hist_base_q[prev_idx];
               w_vert  = hist_vert_q[prev_idx];
               w_len   = 4'(prev_len);
               state_d = StClear;
            end else
`endif
            if (start) begin
               ships_d = '0;
               cur_d   = '0;
            end else if (place) begin
               if (bad_cell) begin
                  err_valid_d = 1'b1;
                  err_code_d  = ErrBadCell;
               end else if (oob) begin
                  err_valid_d = 1'b1;
                  err_code_d  = ErrOutOfBounds;
               end else begin
                  w_load  = 1'b1;
                  state_d = StCheck;
`ifdef FLEET_PLACER_UNDO_EN
                  hist_we = 1'b1;
`endif
               end
            end
         end
         StCheck: begin
            if (ships_q[w_cell]) begin
               err_valid_d = 1'b1;
               err_code_d  = ErrOverlap;
               state_d     = StWait;
            end else if (w_last) begin
               w_rewind = 1'b1;
               state_d  = StCommit;
            end else begin
               w_step = 1'b1;
            end
         end
         StCommit: begin
            ships_d[w_cell] = 1'b1;
            if (w_last) begin
               placed_d = 1'b1;
               cur_d    = cur_q + SW'(1);
               state_d  = (32'(cur_q) + 32'd1 == NUM_SHIPS) ? StDone : StWait;
            end else begin
               w_step = 1'b1;
            end
         end
`ifdef FLEET_PLACER_UNDO_EN
         StClear: begin
            ships_d[w_cell] = 1'b0;
            if (w_last) begin
               cur_d   = cur_q - SW'(1);
               state_d = StWait;
            end else begin
               w_step = 1'b1;
            end
         end
`endif
         StDone: begin
`ifdef FLEET_PLACER_UNDO_EN
            if (undo) begin
               w_load  = 1'b1;
               w_base  = hist_base_q[prev_idx];
               w_vert  = hist_vert_q[prev_idx];
               w_len   = 4'(prev_len);
               state_d = StClear;
            end else
`endif
            if (start) begin
               ships_d = '0;
               cur_d   = '0;
               state_d = StWait;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and output registers; reset discards any partially placed ship.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= StIdle;
         ships_q     <= '0;
         cur_q       <= '0;
         placed_q    <= 1'b0;
         err_valid_q <= 1'b0;
         err_code_q  <= ErrNone;
      end else begin
         state_q     <= state_d;
         ships_q     <= ships_d;
         cur_q       <= cur_d;
         placed_q    <= placed_d;
         err_valid_q <= err_valid_d;
         err_code_q  <= err_code_d;
      end
   end

   ship_cell_walker #(
      .COLS (COLS),
      .XW   (XW),
      .IW   (IW)
   ) u_walker (
      .clk      (clk),
      .reset    (reset),
      .load_i   (w_load),
      .base_i   (w_base),
      .vert_i   (w_vert),
      .len_i    (w_len),
      .rewind_i (w_rewind),
      .step_i   (w_step),
      .cell_o   (w_cell),
      .last_o   (w_last)
   );

   assign ships     = ships_q;
   assign cur_ship  = cur_q;
   assign placed    = placed_q;
   assign err_valid = err_valid_q;
   assign err_code  = err_code_q;
   assign done      = (state_q == StDone);
`ifdef FLEET_PLACER_UNDO_EN
   assign busy      = (state_q == StCheck) || (state_q == StCommit) || (state_q == StClear);
`else
   assign busy      = (state_q == StCheck) || (state_q == StCommit);
`endif

endmodule

// File: tb/tb_fleet_placer.sv
// Scoreboard bench for fleet_placer: a grid-level model predicts each response and its
// arrival cycle; a monitor checks every placed/err_valid pulse against the queue.
module tb_fleet_placer;

   localparam int ROWS = 6;
   localparam int COLS = 6;
   localparam int NS   = 3;
   localparam logic [11:0] LENS = 12'h432;

   logic        clk = 1'b0, reset = 1'b0, start = 1'b0, place = 1'b0;
   logic        vert = 1'b0, undo = 1'b0;
   logic [2:0]  row = '0, col = '0;
   logic [35:0] ships;
   logic [1:0]  cur_ship, err_code;
   logic        busy, placed, err_valid, done;

   fleet_placer dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .place     (place),
      .row       (row),
      .col       (col),
      .vert      (vert),
      .undo      (undo),
      .ships     (ships),
      .cur_ship  (cur_ship),
      .busy      (busy),
      .placed    (placed),
      .err_valid (err_valid),
      .err_code  (err_code),
      .done      (done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_vec = 0, n_bad = 0;

   typedef struct {
      bit          is_err;
      logic [1:0]  code;
      int          due;
      logic [35:0] map;
      int          cur;
   } exp_t;
   exp_t sb[$];

   // Reference model: grid of occupied cells plus placement history.
   bit         occ [ROWS][COLS];
   int         m_cur = 0;
   bit         m_started = 0;
   logic [1:0] m_err = 2'b00;
   int         hr[$], hc[$], hv[$];

   function automatic int slen(int i);
      return int'((LENS >> (4 * i)) & 12'hF);
   endfunction

   function automatic logic [35:0] mmap();
      logic [35:0] m = '0;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            m[r * COLS + c] = occ[r][c];
      return m;
   endfunction

   task automatic model_clear();
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            occ[r][c] = 1'b0;
      m_cur = 0;
      hr.delete(); hc.delete(); hv.delete();
   endtask

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Predict the response to a place command issued during cycle t.
   task automatic model_place(int r, int c, int v, int t);
      exp_t e;
      int   L = slen(m_cur);
      int   hit = -1;
      e.is_err = 1'b1;
      e.code   = 2'b00;
      if (r >= ROWS || c >= COLS) begin
         e.code = 2'b01; e.due = t + 1;
      end else if ((v != 0) ? (r + L > ROWS) : (c + L > COLS)) begin
         e.code = 2'b10; e.due = t + 1;
      end else begin
         for (int k = L - 1; k >= 0; k--)
            if ((v != 0) ? occ[r + k][c] : occ[r][c + k]) hit = k;
         if (hit >= 0) begin
            e.code = 2'b11; e.due = t + hit + 2;
         end else begin
            for (int k = 0; k < L; k++)
               if (v != 0) occ[r + k][c] = 1'b1; else occ[r][c + k] = 1'b1;
            hr.push_back(r); hc.push_back(c); hv.push_back(v);
            m_cur++;
            e.is_err = 1'b0;
            e.due    = t + 2 * L + 1;
         end
      end
      if (e.is_err) m_err = e.code;
      e.map = mmap();
      e.cur = m_cur;
      sb.push_back(e);
   endtask

   // Monitor: every output pulse must match the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      if (reset && (placed || err_valid)) begin
         if (sb.size() == 0) begin
            n_vec++; n_bad++;
            $display("FAIL unexpected_output: placed=%0b err_valid=%0b, expected no pulse (t=%0t)",
                     placed, err_valid, $time);
         end else begin
            e = sb.pop_front();
            chk("ev_err_valid", 64'(err_valid), 64'(e.is_err));
            chk("ev_placed", 64'(placed), 64'(!e.is_err));
            chk("ev_cycle", 64'(cyc), 64'(e.due));
            if (e.is_err) chk("ev_err_code", 64'(err_code), 64'(e.code));
            chk("ev_ships", 64'(ships), 64'(e.map));
            chk("ev_cur_ship", 64'(cur_ship), 64'(e.cur));
         end
      end
   end

   task automatic post_check();
      chk("ships", 64'(ships), 64'(mmap()));
      chk("cur_ship", 64'(cur_ship), 64'(m_cur));
      chk("done", 64'(done), 64'(m_started && m_cur == NS));
      chk("busy", 64'(busy), 64'(0));
      chk("err_code", 64'(err_code), 64'(m_err));
   endtask

   task automatic settle();
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (sb.size() == 0 && !busy) break;
      end
      chk("drain", 64'(sb.size()), 64'(0));
      sb.delete();
      repeat (2) @(negedge clk);
   endtask

   task automatic do_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      model_clear();
      m_started = 1'b1;
      @(negedge clk);
      post_check();
   endtask

   task automatic do_place(int r, int c, int v);
      @(posedge clk); #1;
      row = 3'(r); col = 3'(c); vert = v[0]; place = 1'b1;
      if (m_started && m_cur < NS) model_place(r, c, v, cyc);
      @(posedge clk); #1 place = 1'b0;
      settle();
      post_check();
   endtask

   task automatic do_start_place(int r, int c, int v);
      @(posedge clk); #1;
      row = 3'(r); col = 3'(c); vert = v[0]; place = 1'b1; start = 1'b1;
      @(posedge clk); #1 place = 1'b0; start = 1'b0;
      model_clear();
      m_started = 1'b1;
      settle();
      post_check();
   endtask

   task automatic do_undo();
      int exp_busy = 0;
      int cnt = 0;
      @(posedge clk); #1 undo = 1'b1;
`ifdef FLEET_PLACER_UNDO_EN
      if (m_started && m_cur > 0) begin
         int r = hr.pop_back();
         int c = hc.pop_back();
         int v = hv.pop_back();
         exp_busy = slen(m_cur - 1);
         for (int k = 0; k < exp_busy; k++)
            if (v != 0) occ[r + k][c] = 1'b0; else occ[r][c + k] = 1'b0;
         m_cur--;
      end
`endif
      @(posedge clk); #1 undo = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (busy) cnt++;
      end
      chk("undo_busy_cycles", 64'(cnt), 64'(exp_busy));
      post_check();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      #12;
      chk("rst_ships", 64'(ships), 64'(0));
      chk("rst_cur_ship", 64'(cur_ship), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_done", 64'(done), 64'(0));
      chk("rst_err_code", 64'(err_code), 64'(0));
      #10 reset = 1'b1;

      // Directed sequence.
      do_place(0, 0, 0);          // ignored in IDLE
      do_start();
      do_place(0, 0, 0);          // L=2, placed after 5 cycles
      do_place(5, 4, 0);          // L=3 out of bounds
      do_place(0, 1, 1);          // overlap at k=0
      do_place(6, 0, 0);          // bad cell
      do_place(0, 5, 1);          // column 5, rows 0..2: fits
      do_undo();
      do_place(5, 0, 0);          // L=4 along bottom row
      do_place(2, 2, 0);
      do_undo();
      do_start_place(3, 3, 0);    // start wins
      do_place(1, 0, 1);
      do_place(1, 0, 0);          // overlap at k=0 (1,0)
      do_place(0, 0, 1);          // overlap at k=1 (1,0)

      // Reset during commit of ship 1 (L=3).
      do_start();
      do_place(0, 0, 0);
      @(posedge clk); #1 row = 3'd2; col = 3'd2; vert = 1'b0; place = 1'b1;
      @(posedge clk); #1 place = 1'b0;
      repeat (4) @(posedge clk);
      #1 reset = 1'b0;
      #2;
      sb.delete();
      chk("mid_rst_ships", 64'(ships), 64'(0));
      chk("mid_rst_cur_ship", 64'(cur_ship), 64'(0));
      chk("mid_rst_busy", 64'(busy), 64'(0));
      chk("mid_rst_done", 64'(done), 64'(0));
      chk("mid_rst_placed", 64'(placed), 64'(0));
      chk("mid_rst_err_valid", 64'(err_valid), 64'(0));
      chk("mid_rst_err_code", 64'(err_code), 64'(0));
      model_clear();
      m_started = 1'b0;
      m_err = 2'b00;
      @(negedge clk); reset = 1'b1;
      do_place(1, 1, 0);          // ignored in IDLE after reset

      // Randomized games.
      for (int g = 0; g < 16; g++) begin
         do_start();
         for (int n = 0; n < 30; n++) begin
            if (m_cur == NS) begin
`ifdef FLEET_PLACER_UNDO_EN
               if ($urandom_range(0, 1) == 0) do_undo(); else break;
`else
               do_place(0, 0, 0);  // ignored in DONE
               break;
`endif
            end else if ($urandom_range(0, 7) == 0) begin
               do_undo();
            end else begin
               do_place(int'($urandom_range(0, 6)), int'($urandom_range(0, 6)),
                        int'($urandom_range(0, 1)));
            end
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
